uart_result_tx: RTL and testbench

Transmit-side packet framer for the host UART link. It frames classification results (payload plus label), and receive-side resend requests, into byte packets using the same START/type/checksum/STOP scheme the receiver decodes. It drives a byte-level UART serializer through a valid/ready handshake. It also retransmits the last result packet when the host asks for it.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_result_tx.sv | 145 ++++++++++++++
 tb/tb_uart_result_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared byte codes and tx framer states for the host UART link.
// Imported by both the receive-side decoder and the transmit framer.
package uart_pkg;

  localparam logic [7:0] START_BYTE  = 8'hff;
  localparam logic [7:0] TRAIN_BYTE  = 8'h3c;
  localparam logic [7:0] TEST_BYTE   = 8'hc3;
  localparam logic [7:0] STOP_BYTE   = 8'hbb;
  localparam logic [7:0] RESULT_BYTE = 8'ha5;
  localparam logic [7:0] RESEND_BYTE = 8'h5a;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    TYPE,
    PAYLOAD,
    LABEL,
    CSUM,
    EOF
  } tx_state_t;

endpackage

// File: rtl/uart_result_tx.sv
// Result / resend packet framer feeding the byte serializer.
// Keeps the last result so the host can ask for a replay.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic                       uart_sampling_clk,
  input  logic                       rst,
  input  logic                       result_valid,
  output logic                       result_ready,
  input  logic [8*PAYLOAD_BYTES-1:0] result_payload,
  input  logic [7:0]                 result_label,
  input  logic                       req_resend,
  input  logic                       host_retx,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy
);

  localparam int CW =
    (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(PAYLOAD_BYTES - 1);

  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] byte_q, byte_n;
  logic [7:0] csum;
  logic is_resend, resend_n;
  logic rs_pend, rt_pend, have_last;
  logic [8*PAYLOAD_BYTES-1:0] last_payload;
  logic [7:0] last_label;
  logic hs, accept, start;

  function automatic logic [7:0] pick(
    input logic [CW-1:0] idx
  );
    return last_payload[
      8*(PAYLOAD_BYTES-1-int'(idx)) +: 8];
  endfunction

  assign tx_byte  = byte_q;
  assign tx_valid = (state != IDLE);
  assign busy     = (state != IDLE);
  assign hs       = tx_valid && tx_ready;

  assign result_ready = (state == IDLE) &&
    !rs_pend && !rt_pend &&
    !req_resend && !host_retx;
  assign accept = result_valid && result_ready;
  assign start  = (state == IDLE) &&
    (rs_pend || rt_pend || accept);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    byte_n   = byte_q;
    resend_n = is_resend;
    unique case (state)
      IDLE: if (start) begin
        state_n  = SOF;
        byte_n   = START_BYTE;
        resend_n = rs_pend;
      end
      SOF: if (hs) begin
        state_n = TYPE;
        byte_n  = is_resend ? RESEND_BYTE
                            : RESULT_BYTE;
      end
      TYPE: if (hs) begin
        if (is_resend) begin
          state_n = EOF;
          byte_n  = STOP_BYTE;
        end else begin
          state_n = PAYLOAD;
          cnt_n   = '0;
          byte_n  = pick('0);
        end
      end
      PAYLOAD: if (hs) begin
        if (cnt == CNT_LAST) begin
          state_n = LABEL;
          byte_n  = last_label;
        end else begin
          cnt_n  = cnt + 1'b1;
          byte_n = pick(cnt + 1'b1);
        end
      end
      // label is still in flight, so fold it in here
      LABEL: if (hs) begin
        state_n = CSUM;
        byte_n  = csum + byte_q;
      end
      CSUM: if (hs) begin
        state_n = EOF;
        byte_n  = STOP_BYTE;
      end
      EOF: if (hs) begin
        state_n = IDLE;
        byte_n  = 8'h00;
      end
      default: begin
        state_n = IDLE;
        byte_n  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge uart_sampling_clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      byte_q       <= 8'h00;
      csum         <= 8'h00;
      is_resend    <= 1'b0;
      rs_pend      <= 1'b0;
      rt_pend      <= 1'b0;
      have_last    <= 1'b0;
      last_payload <= '0;
      last_label   <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      byte_q    <= byte_n;
      is_resend <= resend_n;
      rs_pend   <= req_resend |
        (rs_pend & ~start);
      rt_pend   <= (host_retx & have_last) |
        (rt_pend & ~(start & ~rs_pend));
      if (accept) begin
        last_payload <= result_payload;
        last_label   <= result_label;
        have_last    <= 1'b1;
      end
      if (start)
        csum <= 8'h00;
      else if (hs && (state == PAYLOAD ||
                      state == LABEL))
        csum <= csum + byte_q;
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: table of results plus directed
// resend / retx / backpressure / contention / reset sequences.
module tb_uart_result_tx;

  typedef struct {
    logic [31:0] pay;
    logic [7:0]  lab;
    logic [7:0]  sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        result_valid = 1'b0;
  logic        result_ready;
  logic [31:0] result_payload = '0;
  logic [7:0]  result_label = '0;
  logic        req_resend = 1'b0;
  logic        host_retx = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int popped = 0;
  bit bp_mode = 1'b0;
  logic [7:0] q[$];
  vec_t tbl[5];
  logic [31:0] last_p;
  logic [7:0]  last_l, last_c;

  always #5 clk = ~clk;

  uart_result_tx #(.PAYLOAD_BYTES(4)) dut (
    .uart_sampling_clk(clk),
    .rst(rst),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_payload(result_payload),
    .result_label(result_label),
    .req_resend(req_resend),
    .host_retx(host_retx),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic push_result(input logic [31:0] p,
                             input logic [7:0] l,
                             input logic [7:0] c);
    q.push_back(8'hff);
    q.push_back(8'ha5);
    q.push_back(p[31:24]);
    q.push_back(p[23:16]);
    q.push_back(p[15:8]);
    q.push_back(p[7:0]);
    q.push_back(l);
    q.push_back(c);
    q.push_back(8'hbb);
  endtask

  task automatic push_resend();
    q.push_back(8'hff);
    q.push_back(8'h5a);
    q.push_back(8'hbb);
  endtask

  // result_valid already high: wait for accept, then check latency
  task automatic accept_wait(input logic [31:0] p,
                             input logic [7:0] l,
                             input logic [7:0] c);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (result_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 1);
    if (ok) push_result(p, l, c);
    @(posedge clk); #1;
    result_valid = 1'b0;
    if (ok) begin
      @(negedge clk);
      chk("start_valid", 32'(tx_valid), 1);
      chk("start_byte", 32'(tx_byte), 32'hff);
      last_p = p;
      last_l = l;
      last_c = c;
    end
  endtask

  task automatic send_result(input logic [31:0] p,
                             input logic [7:0] l,
                             input logic [7:0] c);
    @(posedge clk); #1;
    result_valid   = 1'b1;
    result_payload = p;
    result_label   = l;
    accept_wait(p, l, c);
  endtask

  task automatic wait_idle(input string n);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(n, 32'(ok), 1);
    if (!ok) q.delete();
  endtask

  task automatic pulse(input bit rs, input bit rt);
    @(posedge clk); #1;
    req_resend = rs;
    host_retx  = rt;
    @(posedge clk); #1;
    req_resend = 1'b0;
    host_retx  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h01020304, 8'h02, 8'h0c};
    tbl[1] = '{32'hff808001, 8'h7f, 8'h7f};
    tbl[2] = '{32'h00000000, 8'h00, 8'h00};
    tbl[3] = '{32'hffffffff, 8'hff, 8'hfb};
    tbl[4] = '{32'h12345678, 8'h9a, 8'hae};

    fork
      begin : ready_drv
        int cyc = 0;
        logic [3:0] pat = 4'b1001;
        tx_ready = 1'b1;
        forever begin
          @(posedge clk); #1;
          cyc++;
          tx_ready = bp_mode ? pat[cyc % 4] : 1'b1;
        end
      end
      begin : monitor
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [7:0] pb = 8'h00;
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (rst) begin
            pv = 1'b0;
          end else begin
            if (busy) busy_cnt++;
            if (pv && !pr) begin
              chk("hold_valid", 32'(tx_valid), 1);
              chk("hold_byte", 32'(tx_byte), 32'(pb));
            end
            if (tx_valid && tx_ready) begin
              popped++;
              if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %h want none",
                         tx_byte);
              end else begin
                e = q.pop_front();
                chk("tx_byte", 32'(tx_byte), 32'(e));
              end
            end
            pv = tx_valid;
            pr = tx_ready;
            pb = tx_byte;
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_byte", 32'(tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(result_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      busy_cnt = 0;
      send_result(tbl[i].pay, tbl[i].lab, tbl[i].sum);
      wait_idle("idle_result");
      chk("busy_cycles", 32'(busy_cnt), 9);
    end

    busy_cnt = 0;
    push_resend();
    pulse(1'b1, 1'b0);
    wait_idle("idle_resend");
    chk("resend_cycles", 32'(busy_cnt), 3);

    busy_cnt = 0;
    push_result(last_p, last_l, last_c);
    pulse(1'b0, 1'b1);
    wait_idle("idle_retx");
    chk("retx_cycles", 32'(busy_cnt), 9);

    bp_mode = 1'b1;
    send_result(tbl[0].pay, tbl[0].lab, tbl[0].sum);
    wait_idle("idle_bp");
    bp_mode = 1'b0;

    @(posedge clk); #1;
    result_valid   = 1'b1;
    result_payload = tbl[1].pay;
    result_label   = tbl[1].lab;
    req_resend     = 1'b1;
    host_retx      = 1'b1;
    @(negedge clk);
    chk("contend_ready", 32'(result_ready), 0);
    push_resend();
    push_result(last_p, last_l, last_c);
    @(posedge clk); #1;
    req_resend = 1'b0;
    host_retx  = 1'b0;
    accept_wait(tbl[1].pay, tbl[1].lab, tbl[1].sum);
    wait_idle("idle_contend");

    popped = 0;
    send_result(tbl[0].pay, tbl[0].lab, tbl[0].sum);
    for (int k = 0; k < 50; k++) begin
      if (popped >= 5) break;
      @(negedge clk); #1;
    end
    chk("reached_byte3", 32'(popped), 5);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_valid", 32'(tx_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_byte", 32'(tx_byte), 0);
    q.delete();
    rst = 1'b0;
    busy_cnt = 0;
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("no_retx_busy", 32'(busy_cnt), 0);
    chk("no_retx_ready", 32'(result_ready), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
